extreme_meas: RTL

Windowed signed-extreme measurement block for the DSP measurement library. It reports the minimum, maximum and, optionally, the peak-to-peak value of a valid-qualified sample stream over programmable windows of `range` accepted samples. Windows run back-to-back with no lost samples. `range == 0` selects continuous tracking. It sits after ADC capture or filter stages and feeds the register and display paths.

---
 rtl/meas_pkg.sv | 22 ++
 rtl/extreme_meas_if.sv | 38 +++
 rtl/meas_window_cnt.sv | 81 ++++++++
 rtl/extreme_meas.sv | 112 +++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
`default_nettype none
// ============================================================================
// Module      : meas_pkg
// Description : Types and default widths shared by the measurement blocks
//               (extreme, mean, RMS). Holds the window state enum and the
//               default sample and range widths.
// Revision    : 1.0 - initial release
// ============================================================================
package meas_pkg;

  // Default sample width (signed two's complement) and window-length width
  localparam int unsigned c_DATA_WIDTH  = 12;
  localparam int unsigned c_RANGE_WIDTH = 10;

  // Window state: IDLE waits for a seeding sample, ACC accumulates
  typedef enum logic [0:0] {
    MEAS_IDLE = 1'b0,
    MEAS_ACC  = 1'b1
  } meas_state_t;

endpackage : meas_pkg
`default_nettype wire

// File: rtl/extreme_meas_if.sv
`default_nettype none
// ============================================================================
// Module      : extreme_meas_if
// Description : Sample-stream and result bus of the extreme measurement block.
//   master : drives range, clear, data_valid, data_in; observes results
//   slave  : the measurement block; drives min_out, max_out, p2p_out,
//            out_valid, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface extreme_meas_if
  import meas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = c_DATA_WIDTH,
  parameter int unsigned RANGE_WIDTH = c_RANGE_WIDTH
);

  logic        [RANGE_WIDTH-1:0] range;      // window length, 0 = continuous
  logic                          clear;      // synchronous restart
  logic                          data_valid; // qualifies data_in
  logic signed [DATA_WIDTH-1:0]  data_in;    // signed sample
  logic signed [DATA_WIDTH-1:0]  min_out;    // window minimum
  logic signed [DATA_WIDTH-1:0]  max_out;    // window maximum
  logic        [DATA_WIDTH:0]    p2p_out;    // unsigned max - min
  logic                          out_valid;  // one-cycle result strobe
  logic                          busy;       // window partially accumulated

  modport master (
    output range, clear, data_valid, data_in,
    input  min_out, max_out, p2p_out, out_valid, busy
  );

  modport slave (
    input  range, clear, data_valid, data_in,
    output min_out, max_out, p2p_out, out_valid, busy
  );

endinterface : extreme_meas_if
`default_nettype wire

// File: rtl/meas_window_cnt.sv
`default_nettype none
// ============================================================================
// Module      : meas_window_cnt
// Description : Window sequencer shared by the measurement blocks. Latches the
//               window length on the seeding sample, counts accepted samples
//               and flags the sample that closes the window.
//   clk_in    : clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   i_clear   : discard the partial window, return to IDLE
//   i_accept  : a sample is accepted this cycle (already gated by clear)
//   i_range   : window length, 0 = continuous
//   o_seed    : accepted sample starts a new window
//   o_close   : accepted sample completes the window
//   o_update  : results must load this cycle (close or continuous sample)
//   o_busy    : window partially accumulated (never in continuous mode)
// Revision    : 1.0 - initial release
// ============================================================================
module meas_window_cnt
  import meas_pkg::*;
#(
  parameter int unsigned RANGE_WIDTH = c_RANGE_WIDTH
) (
  input  wire logic                   clk_in,
  input  wire logic                   rst_n,
  input  wire logic                   i_clear,
  input  wire logic                   i_accept,
  input  wire logic [RANGE_WIDTH-1:0] i_range,
  output logic                        o_seed,
  output logic                        o_close,
  output logic                        o_update,
  output logic                        o_busy
);

  meas_state_t            r_state;
  logic [RANGE_WIDTH-1:0] r_cnt;
  logic [RANGE_WIDTH-1:0] r_range_q;

  logic                   w_seed;
  logic                   w_cont;
  logic                   w_close;
  logic [RANGE_WIDTH-1:0] w_range_eff;
  logic [RANGE_WIDTH-1:0] w_cnt_next;

  // The seeding sample sees the live range; every later sample sees the
  // latched copy, so mid-window range changes wait for the next window.
  assign w_seed      = i_accept && (r_state == MEAS_IDLE);
  assign w_range_eff = w_seed ? i_range : r_range_q;
  assign w_cnt_next  = w_seed ? RANGE_WIDTH'(1) : r_cnt + RANGE_WIDTH'(1);
  assign w_cont      = (w_range_eff == '0);
  // Range 1 closes on the seed itself (cnt_next == 1); max range closes at
  // 2^RANGE_WIDTH-1, so the counter never wraps.
  assign w_close     = i_accept && !w_cont && (w_cnt_next == w_range_eff);

  assign o_seed   = w_seed;
  assign o_close  = w_close;
  assign o_update = i_accept && (w_close || w_cont);
  assign o_busy   = (r_state == MEAS_ACC) && (r_range_q != '0);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= MEAS_IDLE;
      r_cnt     <= '0;
      r_range_q <= '0;
    end else if (i_clear) begin
      r_state <= MEAS_IDLE;
      r_cnt   <= '0;
    end else if (i_accept) begin
      r_range_q <= w_range_eff;
      if (w_close) begin
        r_state <= MEAS_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= MEAS_ACC;
        // Continuous mode has no window end; hold the count so it cannot wrap
        r_cnt   <= w_cont ? RANGE_WIDTH'(1) : w_cnt_next;
      end
    end
  end

endmodule : meas_window_cnt
`default_nettype wire

// File: rtl/extreme_meas.sv
`default_nettype none
// ============================================================================
// Module      : extreme_meas
// Description : Windowed signed min/max (and optional peak-to-peak) of a
//               valid-qualified sample stream. Windows of `range` accepted
//               samples run back-to-back; range 0 tracks continuously.
//   clk_in    : clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   s         : extreme_meas_if.slave - stream inputs and registered results
// Configuration:
//   EXTREME_MEAS_P2P_EN defined   -> p2p subtractor and register built
//   EXTREME_MEAS_P2P_EN undefined -> p2p_out tied to 0
// Revision    : 1.0 - initial release
// ============================================================================
module extreme_meas
  import meas_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = c_DATA_WIDTH,
  parameter int unsigned RANGE_WIDTH = c_RANGE_WIDTH
) (
  input  wire logic      clk_in,
  input  wire logic      rst_n,
  extreme_meas_if.slave  s
);

  logic signed [DATA_WIDTH-1:0] r_acc_min;
  logic signed [DATA_WIDTH-1:0] r_acc_max;
  logic signed [DATA_WIDTH-1:0] r_min_out;
  logic signed [DATA_WIDTH-1:0] r_max_out;
  logic                         r_out_valid;

  logic                         w_accept;
  logic                         w_seed;
  logic                         w_close;
  logic                         w_update;
  logic                         w_busy;
  logic signed [DATA_WIDTH-1:0] w_new_min;
  logic signed [DATA_WIDTH-1:0] w_new_max;

  // clear wins over a simultaneous valid sample
  assign w_accept = s.data_valid && !s.clear;

  meas_window_cnt #(
    .RANGE_WIDTH (RANGE_WIDTH)
  ) u_window_cnt (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_clear  (s.clear),
    .i_accept (w_accept),
    .i_range  (s.range),
    .o_seed   (w_seed),
    .o_close  (w_close),
    .o_update (w_update),
    .o_busy   (w_busy)
  );

  // Extremes including the current sample; a seed restarts from the sample
  assign w_new_min = (w_seed || (s.data_in < r_acc_min)) ? s.data_in : r_acc_min;
  assign w_new_max = (w_seed || (s.data_in > r_acc_max)) ? s.data_in : r_acc_max;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_min   <= '0;
      r_acc_max   <= '0;
      r_min_out   <= '0;
      r_max_out   <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_update;
      if (w_accept) begin
        r_acc_min <= w_new_min;
        r_acc_max <= w_new_max;
      end
      if (w_update) begin
        r_min_out <= w_new_min;
        r_max_out <= w_new_max;
      end
    end
  end

`ifdef EXTREME_MEAS_P2P_EN
  logic [DATA_WIDTH:0] r_p2p_out;
  logic [DATA_WIDTH:0] w_p2p;

  // One extra bit so full-scale max - min cannot overflow
  assign w_p2p = {w_new_max[DATA_WIDTH-1], w_new_max}
               - {w_new_min[DATA_WIDTH-1], w_new_min};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_p2p_out <= '0;
    end else if (w_update) begin
      r_p2p_out <= w_p2p;
    end
  end

  assign s.p2p_out = r_p2p_out;
`else
  assign s.p2p_out = '0;
`endif

  assign s.min_out   = r_min_out;
  assign s.max_out   = r_max_out;
  assign s.out_valid = r_out_valid;
  assign s.busy      = w_busy;

  // close is implied by update in window mode; kept visible for debug taps
  logic w_unused;
  assign w_unused = w_close;

endmodule : extreme_meas
`default_nettype wire
